// File: rtl/core_param_cpu.sv
// Parameterised accumulator-style CPU: 4-state FSM, register file, Z/C flags,
// writable program memory and a single registered I/O port.
module core_param_cpu #(
    parameter int DATA_W     = 8,
    parameter int NREG       = 4,
    parameter int PROG_DEPTH = 16,
    localparam int RW = $clog2(NREG),
    localparam int PW = $clog2(PROG_DEPTH),
    localparam int IW = 4 + 2*RW + DATA_W
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              enable,
    input  logic              run,
    input  logic              prog_we,
    input  logic [PW-1:0]     prog_addr,
    input  logic [IW-1:0]     prog_data,
    input  logic [DATA_W-1:0] port_in,
    output logic [DATA_W-1:0] port_out,
    output logic              port_oe,
    output logic [PW-1:0]     pc,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;
    typedef enum logic [3:0] {
        OP_NOP, OP_LDI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR,  OP_XOR,
        OP_NOT, OP_IN,  OP_OUT, OP_JMP, OP_JZ,  OP_JC,  OP_SHL, OP_HALT
    } op_t;

    state_t            state;
    logic [IW-1:0]     mem [PROG_DEPTH];
    logic [IW-1:0]     ir;
    logic [DATA_W-1:0] regs [NREG];
    logic              z_flag, c_flag;

    op_t               op;
    logic [RW-1:0]     rd, rs;
    logic [DATA_W-1:0] imm, a, b;
    logic [DATA_W:0]   res;
    logic              wr_reg, upd_flags;
    logic [PW-1:0]     next_pc;

    assign op  = op_t'(ir[IW-1 -: 4]);
    assign rd  = ir[IW-5 -: RW];
    assign rs  = ir[IW-5-RW -: RW];
    assign imm = ir[DATA_W-1:0];
    assign a   = regs[rd];
    assign b   = regs[rs];

    // res[DATA_W] carries carry/borrow/shifted-out bit for flag-updating ops
    always_comb begin
        res       = '0;
        wr_reg    = 1'b0;
        upd_flags = 1'b0;
        next_pc   = pc + PW'(1);
        case (op)
            OP_LDI:  begin res = {1'b0, imm};         wr_reg = 1'b1; end
            OP_MOV:  begin res = {1'b0, b};           wr_reg = 1'b1; end
            OP_ADD:  begin res = {1'b0, a} + {1'b0, b}; wr_reg = 1'b1; upd_flags = 1'b1; end
            OP_SUB:  begin res = {1'b0, a} - {1'b0, b}; wr_reg = 1'b1; upd_flags = 1'b1; end
            OP_AND:  begin res = {1'b0, a & b};       wr_reg = 1'b1; upd_flags = 1'b1; end
            OP_OR:   begin res = {1'b0, a | b};       wr_reg = 1'b1; upd_flags = 1'b1; end
            OP_XOR:  begin res = {1'b0, a ^ b};       wr_reg = 1'b1; upd_flags = 1'b1; end
            OP_NOT:  begin res = {1'b0, ~a};          wr_reg = 1'b1; upd_flags = 1'b1; end
            OP_IN:   begin res = {1'b0, port_in};     wr_reg = 1'b1; end
            OP_SHL:  begin res = {a, 1'b0};           wr_reg = 1'b1; upd_flags = 1'b1; end
            OP_JMP:  next_pc = imm[PW-1:0];
            OP_JZ:   if (z_flag) next_pc = imm[PW-1:0];
            OP_JC:   if (c_flag) next_pc = imm[PW-1:0];
            OP_HALT: next_pc = pc;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state    <= S_IDLE;
            pc       <= '0;
            ir       <= '0;
            z_flag   <= 1'b0;
            c_flag   <= 1'b0;
            port_out <= '0;
            port_oe  <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT: if (run) begin
                    state  <= S_FETCH;
                    pc     <= '0;
                    busy   <= 1'b1;
                    halted <= 1'b0;
                end
                S_FETCH: if (enable) begin
                    ir    <= mem[pc];
                    state <= S_EXEC;
                end
                S_EXEC: if (enable) begin
                    if (wr_reg) regs[rd] <= res[DATA_W-1:0];
                    if (upd_flags) begin
                        z_flag <= (res[DATA_W-1:0] == '0);
                        c_flag <= res[DATA_W];
                    end
                    if (op == OP_OUT) begin
                        port_out <= a;
                        port_oe  <= 1'b1;
                    end
                    if (op == OP_IN) port_oe <= 1'b0;
                    pc <= next_pc;
                    if (op == OP_HALT) begin
                        state  <= S_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Program memory is deliberately not reset; loads are only accepted while stopped
    always_ff @(posedge clk) begin
        if (prog_we && (state == S_IDLE || state == S_HALT))
            mem[prog_addr] <= prog_data;
    end

endmodule
